// File: rtl/sram_mem_arbiter_pkg.sv
// Shared types and default sizing for the IF/MEM single-port SRAM arbiter.
package sram_mem_arbiter_pkg;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StAccess = 2'd1,
    StDone   = 2'd2
  } state_e;

  typedef enum logic {
    GntIf   = 1'b0,
    GntData = 1'b1
  } gnt_e;

  localparam int unsigned LenDefault        = 32;
  localparam int unsigned SramAwDefault     = 18;
  localparam int unsigned WaitCyclesDefault = 2;

endpackage

// File: rtl/sram_mem_arbiter.sv
// Arbitrates one asynchronous single-port word SRAM between instruction fetch and the data port,
// stretching each access by WAIT_CYCLES and freezing the pipeline until all requests are served.
module sram_mem_arbiter
  import sram_mem_arbiter_pkg::*;
#(
  parameter int unsigned LEN         = LenDefault,
  parameter int unsigned SRAM_AW     = SramAwDefault,
  parameter int unsigned WAIT_CYCLES = WaitCyclesDefault
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               if_req,
  input  logic [LEN-1:0]     if_addr,
  output logic [LEN-1:0]     if_rdata,
  output logic               if_ready,
  input  logic               mem_r_en,
  input  logic               mem_w_en,
  input  logic [LEN-1:0]     mem_addr,
  input  logic [LEN-1:0]     mem_wdata,
  output logic [LEN-1:0]     mem_rdata,
  output logic               mem_ready,
  output logic               pipe_freeze,
  output logic [SRAM_AW-1:0] sram_addr,
  output logic [LEN-1:0]     sram_dq_out,
  output logic               sram_dq_oe,
  input  logic [LEN-1:0]     sram_dq_in,
  output logic               sram_ce_n,
  output logic               sram_oe_n,
  output logic               sram_we_n
);

  localparam int unsigned CntW = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;

  state_e             state_q, state_d;
  gnt_e               gnt_q, gnt_d;
  logic               wr_q, wr_d;
  logic [CntW-1:0]    cnt_q, cnt_d;
  logic [SRAM_AW-1:0] addr_q, addr_d;
  logic [LEN-1:0]     wdata_q, wdata_d;
  logic               i_done_q, d_done_q;
  logic [LEN-1:0]     if_rdata_q, mem_rdata_q;
  logic               ce_n_q, oe_n_q, we_n_q, dq_oe_q;
  logic               ce_n_d, oe_n_d, we_n_d, dq_oe_d;

  logic d_req, d_pend, i_pend, access_last;

  assign d_req       = mem_r_en | mem_w_en;
  assign d_pend      = d_req & ~d_done_q;
  assign i_pend      = if_req & ~i_done_q;
  assign access_last = (state_q == StAccess) && (cnt_q == '0);

  assign if_ready    = i_done_q | ~if_req;
  assign mem_ready   = d_done_q | ~d_req;
  assign pipe_freeze = reset & ~(if_ready & mem_ready);

  // Byte-lane bits and address bits above the SRAM window are intentionally ignored.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{if_addr[LEN-1:SRAM_AW+2], if_addr[1:0],
                              mem_addr[LEN-1:SRAM_AW+2], mem_addr[1:0]};

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // DONE also arbitrates so a second queued requester starts without an idle bubble.
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    wr_d    = wr_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    unique case (state_q)
      StIdle, StDone: begin
        state_d = StIdle;
        if (d_pend) begin
          state_d = StAccess;
          gnt_d   = GntData;
          wr_d    = mem_w_en;
          cnt_d   = CntW'(WAIT_CYCLES);
          addr_d  = mem_addr[SRAM_AW+1:2];
          wdata_d = mem_wdata;
        end else if (i_pend) begin
          state_d = StAccess;
          gnt_d   = GntIf;
          wr_d    = 1'b0;
          cnt_d   = CntW'(WAIT_CYCLES);
          addr_d  = if_addr[SRAM_AW+1:2];
        end
      end
      StAccess: begin
        if (cnt_q == '0) begin
          state_d = StDone;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // SRAM strobes are registered from the next state so they are glitch-free at the pins.
  always_comb begin
    ce_n_d  = (state_d != StAccess);
    oe_n_d  = !((state_d == StAccess) && !wr_d);
    we_n_d  = !((state_d == StAccess) && wr_d);
    dq_oe_d = (state_d == StAccess) && wr_d;
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      gnt_q       <= GntIf;
      wr_q        <= 1'b0;
      cnt_q       <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      ce_n_q      <= 1'b1;
      oe_n_q      <= 1'b1;
      we_n_q      <= 1'b1;
      dq_oe_q     <= 1'b0;
      i_done_q    <= 1'b0;
      d_done_q    <= 1'b0;
      if_rdata_q  <= '0;
      mem_rdata_q <= '0;
    end else begin
      gnt_q   <= gnt_d;
      wr_q    <= wr_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      ce_n_q  <= ce_n_d;
      oe_n_q  <= oe_n_d;
      we_n_q  <= we_n_d;
      dq_oe_q <= dq_oe_d;
      if (!pipe_freeze) begin
        i_done_q <= 1'b0;
        d_done_q <= 1'b0;
      end else if (access_last) begin
        if (gnt_q == GntData) begin
          d_done_q <= 1'b1;
        end else begin
          i_done_q <= 1'b1;
        end
      end
      if (access_last && !wr_q) begin
        if (gnt_q == GntData) begin
          mem_rdata_q <= sram_dq_in;
        end else begin
          if_rdata_q <= sram_dq_in;
        end
      end
    end
  end

  assign if_rdata    = if_rdata_q;
  assign mem_rdata   = mem_rdata_q;
  assign sram_addr   = addr_q;
  assign sram_dq_out = wdata_q;
  assign sram_dq_oe  = dq_oe_q;
  assign sram_ce_n   = ce_n_q;
  assign sram_oe_n   = oe_n_q;
  assign sram_we_n   = we_n_q;

endmodule

// File: tb/tb_sram_mem_arbiter.sv
// Scoreboard bench for sram_mem_arbiter: a driver queues expected pipeline-cycle results and SRAM
// access windows, while independent monitors check them as the DUT presents them.
module tb_sram_mem_arbiter;

  typedef struct {
    logic        chk_if;
    logic [31:0] if_data;
    logic        chk_mem;
    logic [31:0] mem_data;
    int          t_start;
    int          lat;
  } sb_t;

  typedef struct {
    logic [17:0] addr;
    logic        wr;
    logic [31:0] wdata;
    int          len;
  } bus_t;

  logic        clk = 1'b0;
  logic        reset;
  int          cyc = 0;
  int          n_vec = 0;
  int          n_err = 0;

  logic        if_req, mem_r_en, mem_w_en;
  logic [31:0] if_addr, mem_addr, mem_wdata;
  logic [31:0] if_rdata, mem_rdata, sram_dq_out, sram_dq_in;
  logic        if_ready, mem_ready, pipe_freeze, sram_dq_oe, sram_ce_n, sram_oe_n, sram_we_n;
  logic [17:0] sram_addr;

  logic        if_req0;
  logic [31:0] if_addr0, if_rdata0, mem_rdata0, sram_dq_out0, sram_dq_in0;
  logic        if_ready0, mem_ready0, freeze0, dq_oe0, ce_n0, oe_n0, we_n0;
  logic [17:0] sram_addr0;

  logic [31:0] sram_mem [0:1023];
  sb_t         sb_q[$];
  bus_t        bus_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  sram_mem_arbiter #(.LEN(32), .SRAM_AW(18), .WAIT_CYCLES(2)) dut (
    .clock(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ready(if_ready),
    .mem_r_en(mem_r_en), .mem_w_en(mem_w_en), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready), .pipe_freeze(pipe_freeze),
    .sram_addr(sram_addr), .sram_dq_out(sram_dq_out), .sram_dq_oe(sram_dq_oe),
    .sram_dq_in(sram_dq_in), .sram_ce_n(sram_ce_n), .sram_oe_n(sram_oe_n), .sram_we_n(sram_we_n)
  );

  sram_mem_arbiter #(.LEN(32), .SRAM_AW(18), .WAIT_CYCLES(0)) dut0 (
    .clock(clk), .reset(reset),
    .if_req(if_req0), .if_addr(if_addr0), .if_rdata(if_rdata0), .if_ready(if_ready0),
    .mem_r_en(1'b0), .mem_w_en(1'b0), .mem_addr(32'h0), .mem_wdata(32'h0),
    .mem_rdata(mem_rdata0), .mem_ready(mem_ready0), .pipe_freeze(freeze0),
    .sram_addr(sram_addr0), .sram_dq_out(sram_dq_out0), .sram_dq_oe(dq_oe0),
    .sram_dq_in(sram_dq_in0), .sram_ce_n(ce_n0), .sram_oe_n(oe_n0), .sram_we_n(we_n0)
  );

  // Simple SRAM models: the W=2 one is a real memory, the W=0 one returns an address pattern.
  assign sram_dq_in  = (sram_ce_n == 1'b0 && sram_oe_n == 1'b0) ? sram_mem[sram_addr[9:0]]
                                                                : 32'hBAD0_BAD0;
  assign sram_dq_in0 = (ce_n0 == 1'b0 && oe_n0 == 1'b0) ? (32'hF000_0000 | 32'(sram_addr0))
                                                        : 32'hBAD0_BAD0;

  always @(posedge clk) begin
    if (sram_ce_n == 1'b0 && sram_we_n == 1'b0 && sram_dq_oe == 1'b1) begin
      sram_mem[sram_addr[9:0]] <= sram_dq_out;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push_bus(input logic [17:0] a, input logic wr, input logic [31:0] wd,
                          input int len);
    bus_t b;
    b.addr = a; b.wr = wr; b.wdata = wd; b.len = len;
    bus_q.push_back(b);
  endtask

  task automatic drop_reqs();
    if_req = 1'b0; mem_r_en = 1'b0; mem_w_en = 1'b0;
  endtask

  task automatic run_txn(input logic i_en, input logic [31:0] ia, input logic [31:0] i_exp,
                         input logic rd, input logic wr, input logic [31:0] da,
                         input logic [31:0] wd, input logic [31:0] m_exp, input int lat);
    sb_t e;
    logic done;
    @(posedge clk); #1;
    if_req = i_en; if_addr = ia; mem_r_en = rd; mem_w_en = wr; mem_addr = da; mem_wdata = wd;
    e.chk_if = i_en; e.if_data = i_exp; e.chk_mem = rd | wr; e.mem_data = m_exp;
    e.t_start = cyc; e.lat = lat;
    sb_q.push_back(e);
    done = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (!pipe_freeze) begin
        done = 1'b1;
        break;
      end
    end
    if (!done) begin
      n_vec++; n_err++;
      $display("FAIL txn_timeout: pipe_freeze still 1 after 40 cycles, expected release");
    end
    @(posedge clk); #1;
    drop_reqs();
  endtask

  // Result monitor: one pipeline cycle completes whenever the freeze drops with a request up.
  initial begin
    sb_t e;
    forever begin
      @(negedge clk);
      if (reset === 1'b1 && pipe_freeze === 1'b0 && (if_req || mem_r_en || mem_w_en)) begin
        if (sb_q.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL sb_unexpected: pipeline cycle completed with no expectation queued");
        end else begin
          e = sb_q.pop_front();
          check("latency", cyc - e.t_start, e.lat);
          if (e.chk_if) check("if_rdata", if_rdata, e.if_data);
          if (e.chk_mem) check("mem_rdata", mem_rdata, e.mem_data);
        end
      end
    end
  end

  // Bus monitor: each contiguous ce_n-low window is one SRAM access.
  initial begin
    bus_t        cur;
    logic        in_win = 1'b0;
    logic        have_exp = 1'b0;
    logic        win_bad = 1'b0;
    logic [17:0] win_addr = '0;
    int          win_len = 0;
    forever begin
      @(negedge clk);
      if (sram_ce_n === 1'b0) begin
        if (!in_win) begin
          in_win = 1'b1; win_len = 0; win_bad = 1'b0; win_addr = sram_addr;
          if (bus_q.size() == 0) begin
            have_exp = 1'b0;
            n_vec++; n_err++;
            $display("FAIL bus_unexpected: access to word %h, expected none", sram_addr);
          end else begin
            cur = bus_q.pop_front();
            have_exp = 1'b1;
          end
        end
        win_len++;
        if (have_exp && (sram_oe_n !== cur.wr || sram_we_n !== !cur.wr ||
                         sram_dq_oe !== cur.wr || sram_addr !== cur.addr ||
                         (cur.wr && sram_dq_out !== cur.wdata))) win_bad = 1'b1;
      end else if (in_win) begin
        in_win = 1'b0;
        if (have_exp) begin
          check("bus_addr", 32'(win_addr), 32'(cur.addr));
          check("bus_len", win_len, cur.len);
          check("bus_ctrl", 32'(win_bad), 32'h0);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 1024; i++) sram_mem[i] = 32'h0;
    sram_mem[2]     = 32'hDEAD_BEEF;
    sram_mem[3]     = 32'hCAFE_F00D;
    sram_mem[10'h41] = 32'h0BAD_F00D;

    // Reset with requests up: freeze forced low, SRAM deselected.
    reset = 1'b0; if_req = 1'b1; mem_r_en = 1'b0; mem_w_en = 1'b1;
    if_addr = 32'h0; mem_addr = 32'h0; mem_wdata = 32'h0;
    if_req0 = 1'b0; if_addr0 = 32'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_freeze_forced", 32'(pipe_freeze), 32'h0);
    check("rst_ce_n", 32'(sram_ce_n), 32'h1);
    @(posedge clk); #1;
    drop_reqs();
    reset = 1'b1;
    @(negedge clk);
    check("rst_ctrl", {28'h0, sram_ce_n, sram_oe_n, sram_we_n, sram_dq_oe}, 32'hE);
    check("rst_sram_addr", 32'(sram_addr), 32'h0);
    check("rst_dq_out", sram_dq_out, 32'h0);
    check("rst_if_rdata", if_rdata, 32'h0);
    check("rst_mem_rdata", mem_rdata, 32'h0);
    check("rst_idle_freeze", {30'h0, pipe_freeze, if_ready & mem_ready}, 32'h1);

    // IF only.
    push_bus(18'h2, 1'b0, 32'h0, 3);
    run_txn(1, 32'h8, 32'hDEAD_BEEF, 0, 0, 32'h0, 32'h0, 32'h0, 4);

    // Store, then IF readback of the same word.
    push_bus(18'h40, 1'b1, 32'h1234_5678, 3);
    run_txn(0, 32'h0, 32'h0, 0, 1, 32'h100, 32'h1234_5678, 32'h0, 4);
    push_bus(18'h40, 1'b0, 32'h0, 3);
    run_txn(1, 32'h100, 32'h1234_5678, 0, 0, 32'h0, 32'h0, 32'h0, 4);

    // Load and IF together: data first, IF second, no repeat afterwards.
    push_bus(18'h41, 1'b0, 32'h0, 3);
    push_bus(18'h3, 1'b0, 32'h0, 3);
    run_txn(1, 32'hC, 32'hCAFE_F00D, 1, 0, 32'h104, 32'h0, 32'h0BAD_F00D, 8);

    // Store and IF together, held through the freeze: exactly two windows.
    push_bus(18'h80, 1'b1, 32'hA5A5_0001, 3);
    push_bus(18'h41, 1'b0, 32'h0, 3);
    run_txn(1, 32'h104, 32'h0BAD_F00D, 0, 1, 32'h200, 32'hA5A5_0001, 32'h0BAD_F00D, 8);

    // Read and write enables together act as a store; byte-offset bits ignored on readback.
    push_bus(18'h81, 1'b1, 32'h5555_AAAA, 3);
    run_txn(0, 32'h0, 32'h0, 1, 1, 32'h204, 32'h5555_AAAA, 32'h0BAD_F00D, 4);
    push_bus(18'h81, 1'b0, 32'h0, 3);
    run_txn(1, 32'h207, 32'h5555_AAAA, 0, 0, 32'h0, 32'h0, 32'h0, 4);

    // Reset in cycle 2 of a store aborts it with no ready.
    push_bus(18'hC0, 1'b1, 32'h7777_0000, 2);
    @(posedge clk); #1;
    mem_w_en = 1'b1; mem_addr = 32'h300; mem_wdata = 32'h7777_0000;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("abort_freeze_c2", 32'(pipe_freeze), 32'h0);
    @(posedge clk); #1;
    @(negedge clk);
    check("abort_ctrl", {29'h0, sram_ce_n, sram_we_n, sram_dq_oe}, 32'h6);
    check("abort_ready", 32'(mem_ready), 32'h0);
    check("abort_freeze", 32'(pipe_freeze), 32'h0);
    check("abort_rdata_clr", mem_rdata, 32'h0);
    @(posedge clk); #1;
    drop_reqs();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    check("abort_no_repeat", 32'(sram_ce_n), 32'h1);

    // WAIT_CYCLES=0 instance: back-to-back fetches, one ACCESS and one DONE each.
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      if_req0 = 1'b1; if_addr0 = 32'h40 + 32'(4 * k);
      @(negedge clk);
      check("w0_freeze_c0", {30'h0, freeze0, ce_n0}, 32'h3);
      @(negedge clk);
      check("w0_access_c1", {29'h0, ce_n0, oe_n0, freeze0}, 32'h1);
      @(negedge clk);
      check("w0_ready_c2", {29'h0, if_ready0, freeze0, ce_n0}, 32'h5);
      check("w0_rdata", if_rdata0, 32'hF000_0010 + 32'(k));
    end
    @(posedge clk); #1;
    if_req0 = 1'b0;

    repeat (6) @(posedge clk);
    check("sb_leftover", sb_q.size(), 32'h0);
    check("bus_leftover", bus_q.size(), 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
